pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register that succeeds the plain load/clear register. Adds a valid/ready handshake, an optional skid entry and a flush input.
- Sits between pipeline stages (fetch/decode/execute/mem/writeback) of the pipelined LC-3.
- Back-pressure stalls upstream without losing data. Flush kills in-flight instructions on branch or jump redirect.

Parameters:
WIDTH, 16, bit width of the data payload.
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational ready pass-through.
RESET_VAL, 0, value loaded into all data storage on reset or flush (WIDTH bits).

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
flush  input  1  synchronous kill of all held entries.
in_valid  input  1  upstream presents in_data.
in_ready  output  1  stage can accept in_data this cycle.
in_data  input  WIDTH  upstream payload.
out_valid  output  1  out_data holds a valid entry.
out_ready  input  1  downstream consumes out_data this cycle.
out_data  output  WIDTH  head-entry payload, driven directly from a register.
occupancy  output  2  number of held entries (0..2; never above 1 when SKID=0).

Behaviour:
- Transfers:
  - Accept when in_valid && in_ready at a rising edge.
  - Drain when out_valid && out_ready at a rising edge.
- Reset (asynchronous, immediate on assertion):
  - state EMPTY; main and skid = RESET_VAL; out_valid=0; occupancy=0.
  - in_ready=1 for SKID=1, since it is a flop.
  - in_valid is ignored while reset is high.
- Latency:
  - Data accepted at edge N appears on out_data with out_valid=1 after edge N. This is one cycle of latency.
  - No combinational path from in_data to out_data.
- Hold rule: while out_valid && !out_ready, out_data and out_valid stay stable.
- SKID=1 state machine (EMPTY, ONE, FULL):
  - EMPTY: accept -> ONE, main<=in_data.
  - ONE:
    - accept && drain -> ONE, main<=in_data.
    - accept only -> FULL, skid<=in_data.
    - drain only -> EMPTY.
    - neither -> stay.
  - FULL: in_ready=0; drain -> ONE, main<=skid; otherwise stay.
  - in_ready is registered and is 1 exactly when next state is not FULL. There is no combinational path from out_ready to in_ready.
- SKID=0 (states EMPTY, ONE only):
  - in_ready = !out_valid || out_ready (combinational).
  - EMPTY: accept -> ONE, main<=in_data.
  - ONE:
    - accept && drain -> ONE, main<=in_data.
    - drain only -> EMPTY.
    - neither -> stay.
  - Full throughput is kept under continuous flow.
- Flush (synchronous):
  - Highest priority at the edge: state<=EMPTY, main and skid <= RESET_VAL, out_valid<=0.
  - A same-cycle input transfer is dropped.
  - A same-cycle downstream drain still counts as consumed by downstream.
  - For SKID=1, in_ready<=1 after flush.
- occupancy equals 0/1/2 for EMPTY/ONE/FULL and updates at the same edge as state.
- Reset asserted mid-operation: all held entries are lost; the block returns to reset values without waiting for a clock edge.
- No entry is ever duplicated or dropped except by flush or reset.

Test Plan:
1. SKID=1, out_ready=1, stream 0x1111,0x2222,0x3333 on consecutive cycles -> same values out one cycle later, back-to-back; occupancy stays 1; in_ready stays 1.
2. SKID=1, out_ready=0, push 0xAAAA then 0xBBBB:
   - occupancy 1 then 2; in_ready drops to 0 after the second edge; out_data holds 0xAAAA.
   - Raise out_ready -> 0xAAAA then 0xBBBB in order, no loss.
3. SKID=1, FULL, flush=1 with in_valid=1 and in_data=0xCCCC -> next cycle out_valid=0, occupancy=0, out_data=RESET_VAL, in_ready=1; 0xCCCC never appears.
4. SKID=0, out_valid=1, out_ready=0 -> in_ready=0 combinationally. Toggle out_ready=1 with in_valid=1 and in_data=0x1234 -> in_ready=1 the same cycle; 0x1234 replaces the head after the edge.
5. Assert reset between clock edges while FULL -> out_valid=0, occupancy=0, out_data=RESET_VAL immediately, before the next edge.
6. Random in_valid/out_ready, 10k cycles, both SKID values -> scoreboard shows in-order delivery with no duplicates or drops, and out_data stable whenever out_valid && !out_ready.

Source files
------------

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for one pipeline stage register.
//   in_valid/in_ready/in_data    : upstream side (producer -> stage)
//   out_valid/out_ready/out_data : downstream side (stage -> consumer)
//   occupancy                    : number of entries held by the stage
// slave  = the stage's view, master = the driver/observer's view.
interface pipe_stage_reg_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional skid entry
// and synchronous flush.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   flush : synchronous kill of all held entries (drops a same-cycle accept)
//   bus   : handshake bundle (slave view), see pipe_stage_reg_if
// SKID=1 : two entries, in_ready comes straight from a flop.
// SKID=0 : one entry, in_ready = !out_valid || out_ready.
//
// state    | meaning
// ---------+---------------------------------------------------
// ST_EMPTY | nothing held, out_valid=0
// ST_ONE   | head entry in main_q
// ST_FULL  | head in main_q, next entry in skid_q (SKID=1 only)
module pipe_stage_reg #(
    parameter int               WIDTH     = 16,
    parameter bit               SKID      = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    pipe_stage_reg_if.slave bus
);
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready;
    logic             out_valid;
    logic             accept;
    logic             drain;
    logic [1:0]       occupancy;

    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = bus.in_valid && in_ready;
    assign drain     = out_valid && bus.out_ready;

    generate
        if (SKID) begin : g_skid
            logic in_ready_q;

            // Registered ready: looks one state ahead so it never depends on
            // this cycle's out_ready.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= (state_d != ST_FULL);
                end
            end

            assign in_ready = in_ready_q;
        end else begin : g_noskid
            assign in_ready = !out_valid || bus.out_ready;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            main_q  <= RESET_VAL;
            skid_q  <= RESET_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = RESET_VAL;
            skid_d  = RESET_VAL;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        main_d  = bus.in_data;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        main_d = bus.in_data;
                    end else if (accept) begin
                        // Without a skid entry accept implies drain here.
                        if (SKID) begin
                            state_d = ST_FULL;
                            skid_d  = bus.in_data;
                        end
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_comb begin
        occupancy = 2'd0;
        case (state_q)
            ST_ONE:  occupancy = 2'd1;
            ST_FULL: occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = main_q;
    assign bus.occupancy = occupancy;
endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
    localparam logic [15:0] RV = 16'h00F0;

    logic clk;
    logic reset;
    logic flush1;
    logic flush0;

    int total = 0;
    int bad   = 0;

    pipe_stage_reg_if #(.WIDTH(16)) b1 ();
    pipe_stage_reg_if #(.WIDTH(16)) b0 ();

    pipe_stage_reg #(.WIDTH(16), .SKID(1'b1), .RESET_VAL(RV)) dut1 (
        .clk(clk), .reset(reset), .flush(flush1), .bus(b1)
    );
    pipe_stage_reg #(.WIDTH(16), .SKID(1'b0), .RESET_VAL(RV)) dut0 (
        .clk(clk), .reset(reset), .flush(flush0), .bus(b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        iv;
        logic [15:0] d;
        logic        ordy;
        logic        fl;
        logic        ov;
        logic [15:0] od;
        logic        chk_d;
        logic [1:0]  occ;
        logic        ir;
    } vec_t;

    function automatic vec_t mk(logic iv, logic [15:0] d, logic ordy, logic fl,
                                logic ov, logic [15:0] od, logic chk_d,
                                logic [1:0] occ, logic ir);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
        v.ov = ov; v.od = od; v.chk_d = chk_d; v.occ = occ; v.ir = ir;
        return v;
    endfunction

    task automatic idle_inputs();
        b1.in_valid = 1'b0; b1.in_data = 16'h0; b1.out_ready = 1'b0; flush1 = 1'b0;
        b0.in_valid = 1'b0; b0.in_data = 16'h0; b0.out_ready = 1'b0; flush0 = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    vec_t vt[$];
    logic [15:0] q1[$];
    logic [15:0] q0[$];

    initial begin
        reset = 1'b1;
        idle_inputs();

        vt.push_back(mk(1, 16'h1111, 1, 0, 1, 16'h1111, 1, 1, 1));
        vt.push_back(mk(1, 16'h2222, 1, 0, 1, 16'h2222, 1, 1, 1));
        vt.push_back(mk(1, 16'h3333, 1, 0, 1, 16'h3333, 1, 1, 1));
        vt.push_back(mk(0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 1));
        vt.push_back(mk(1, 16'hAAAA, 0, 0, 1, 16'hAAAA, 1, 1, 1));
        vt.push_back(mk(1, 16'hBBBB, 0, 0, 1, 16'hAAAA, 1, 2, 0));
        vt.push_back(mk(1, 16'hDDDD, 0, 0, 1, 16'hAAAA, 1, 2, 0));
        vt.push_back(mk(0, 16'h0000, 1, 0, 1, 16'hBBBB, 1, 1, 1));
        vt.push_back(mk(0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 1));
        vt.push_back(mk(1, 16'hAAAA, 0, 0, 1, 16'hAAAA, 1, 1, 1));
        vt.push_back(mk(1, 16'hBBBB, 0, 0, 1, 16'hAAAA, 1, 2, 0));
        vt.push_back(mk(1, 16'hCCCC, 0, 1, 0, RV,       1, 0, 1));
        vt.push_back(mk(0, 16'h0000, 1, 0, 0, RV,       1, 0, 1));
        vt.push_back(mk(1, 16'h1234, 0, 0, 1, 16'h1234, 1, 1, 1));
        vt.push_back(mk(1, 16'h5678, 1, 1, 0, RV,       1, 0, 1));
        vt.push_back(mk(1, 16'hA001, 0, 0, 1, 16'hA001, 1, 1, 1));
        vt.push_back(mk(1, 16'hA002, 0, 0, 1, 16'hA001, 1, 2, 0));
        vt.push_back(mk(1, 16'hA003, 1, 0, 1, 16'hA002, 1, 1, 1));
        vt.push_back(mk(0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 1));

        // reset values
        do_reset();
        #1;
        chk("rst1_ov",  b1.out_valid, 0);
        chk("rst1_occ", b1.occupancy, 0);
        chk("rst1_od",  b1.out_data,  RV);
        chk("rst1_ir",  b1.in_ready,  1);
        chk("rst0_ov",  b0.out_valid, 0);
        chk("rst0_ir",  b0.in_ready,  1);
        chk("rst0_od",  b0.out_data,  RV);

        // table vectors, SKID=1
        foreach (vt[i]) begin
            b1.in_valid = vt[i].iv; b1.in_data = vt[i].d;
            b1.out_ready = vt[i].ordy; flush1 = vt[i].fl;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_ov", i),  b1.out_valid, vt[i].ov);
            chk($sformatf("vec%0d_occ", i), b1.occupancy, vt[i].occ);
            chk($sformatf("vec%0d_ir", i),  b1.in_ready,  vt[i].ir);
            if (vt[i].chk_d) chk($sformatf("vec%0d_od", i), b1.out_data, vt[i].od);
        end
        idle_inputs();

        // SKID=0: combinational ready and replace-on-drain
        b0.in_valid = 1'b1; b0.in_data = 16'h4321; b0.out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("s0_first_ov",  b0.out_valid, 1);
        chk("s0_first_od",  b0.out_data,  16'h4321);
        chk("s0_first_occ", b0.occupancy, 1);
        b0.in_valid = 1'b1; b0.in_data = 16'h9999; b0.out_ready = 1'b0;
        #1;
        chk("s0_ir_blocked", b0.in_ready, 0);
        @(posedge clk);
        #1;
        chk("s0_hold_od",  b0.out_data,  16'h4321);
        chk("s0_hold_occ", b0.occupancy, 1);
        b0.out_ready = 1'b1; b0.in_data = 16'h1234;
        #1;
        chk("s0_ir_pass", b0.in_ready, 1);
        @(posedge clk);
        #1;
        chk("s0_repl_od",  b0.out_data,  16'h1234);
        chk("s0_repl_ov",  b0.out_valid, 1);
        chk("s0_repl_occ", b0.occupancy, 1);
        b0.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("s0_empty_ov", b0.out_valid, 0);
        idle_inputs();

        // async reset while FULL, between edges
        b1.in_valid = 1'b1; b1.in_data = 16'hE001;
        @(posedge clk);
        b1.in_data = 16'hE002;
        @(posedge clk);
        #1;
        b1.in_valid = 1'b0;
        chk("ar_pre_occ", b1.occupancy, 2);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("ar_ov",  b1.out_valid, 0);
        chk("ar_occ", b1.occupancy, 0);
        chk("ar_od",  b1.out_data,  RV);
        chk("ar_ir",  b1.in_ready,  1);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("ar_post_ov", b1.out_valid, 0);

        // randomized run, both variants against queue models
        q1.delete(); q0.delete();
        for (int c = 0; c < 10000; c++) begin
            logic r1, r0, a1, a0, d1, d0, h1, h0, f1, f0;
            logic [15:0] p1, p0;
            b1.in_valid  = ($urandom_range(0, 99) < 70);
            b1.in_data   = 16'($urandom);
            b1.out_ready = ($urandom_range(0, 99) < 50);
            flush1       = ($urandom_range(0, 99) < 3);
            b0.in_valid  = ($urandom_range(0, 99) < 70);
            b0.in_data   = 16'($urandom);
            b0.out_ready = ($urandom_range(0, 99) < 50);
            flush0       = ($urandom_range(0, 99) < 3);
            r1 = (q1.size() < 2);
            r0 = (q0.size() == 0) || b0.out_ready;
            #1;
            chk("rnd1_ir", b1.in_ready, r1);
            chk("rnd0_ir", b0.in_ready, r0);
            a1 = b1.in_valid && r1;
            a0 = b0.in_valid && r0;
            d1 = (q1.size() > 0) && b1.out_ready;
            d0 = (q0.size() > 0) && b0.out_ready;
            h1 = (q1.size() > 0) && !b1.out_ready;
            h0 = (q0.size() > 0) && !b0.out_ready;
            p1 = b1.out_data;
            p0 = b0.out_data;
            f1 = flush1;
            f0 = flush0;
            @(posedge clk);
            #1;
            if (f1) q1.delete();
            else begin
                if (d1) void'(q1.pop_front());
                if (a1) q1.push_back(b1.in_data);
            end
            if (f0) q0.delete();
            else begin
                if (d0) void'(q0.pop_front());
                if (a0) q0.push_back(b0.in_data);
            end
            chk("rnd1_ov",  b1.out_valid, q1.size() > 0);
            chk("rnd1_occ", b1.occupancy, q1.size());
            chk("rnd0_ov",  b0.out_valid, q0.size() > 0);
            chk("rnd0_occ", b0.occupancy, q0.size());
            if (q1.size() > 0) chk("rnd1_od", b1.out_data, q1[0]);
            else if (f1)       chk("rnd1_flush_od", b1.out_data, RV);
            if (q0.size() > 0) chk("rnd0_od", b0.out_data, q0[0]);
            else if (f0)       chk("rnd0_flush_od", b0.out_data, RV);
            if (h1 && !f1) chk("rnd1_hold", b1.out_data, p1);
            if (h0 && !f0) chk("rnd0_hold", b0.out_data, p0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
